// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports, same-cycle write-to-read
// bypass on every read port, and a per-register pending-write scoreboard.
module regfile_mp_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;

  // Address 0 is only special when the zero register is enabled.
  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];
  logic [Depth-1:0]  pending_q, pending_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic wr0_ok, wr1_ok, iss_ok;

  assign wr0_ok = wr0_en && !is_zero(wr0_addr);
  assign wr1_ok = wr1_en && !is_zero(wr1_addr);
  assign iss_ok = iss_en && !is_zero(iss_addr);

  // Next register contents; wr1 is applied last so it wins an address collision.
  always_comb begin
    regs_d = regs_q;
    if (wr0_ok) regs_d[wr0_addr] = wr0_data;
    if (wr1_ok) regs_d[wr1_addr] = wr1_data;
  end

  // Register storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Scoreboard next state: writes clear, then an issue sets (new producer wins).
  always_comb begin
    pending_d = pending_q;
    if (wr0_en) pending_d[wr0_addr] = 1'b0;
    if (wr1_en) pending_d[wr1_addr] = 1'b0;
    if (iss_ok) pending_d[iss_addr] = 1'b1;
  end

  // Count is taken from the next pending vector so it lands on the same edge.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < Depth; i++) begin
      cnt_d = cnt_d + CntW'(pending_d[i]);
    end
  end

  // Scoreboard and pending count state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit0, hit1;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit0 = wr0_en && (wr0_addr == addr);
    assign hit1 = wr1_en && (wr1_addr == addr);

    // Read mux: zero register, then wr1 bypass, then wr0 bypass, then storage.
    // Outputs are held at zero while reset is asserted, bypass included.
    always_comb begin
      data = regs_q[addr];
      if (reset || is_zero(addr)) begin
        data = '0;
      end else if (hit1) begin
        data = wr1_data;
      end else if (hit0) begin
        data = wr0_data;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k] = !reset && !is_zero(addr) && pending_q[addr] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: default config, ZERO_REG=0 config (sharing inputs) and a
// wide 4-read-port config, against a behavioural register file model.
module tb_regfile_mp_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Shared stimulus for the two 32x32, 2-read-port instances.
  logic [9:0]  rd_addr;
  logic        wr0_en, wr1_en, iss_en;
  logic [4:0]  wr0_addr, wr1_addr, iss_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [63:0] rd_data_z, rd_data_n;
  logic [1:0]  rd_busy_z, rd_busy_n;
  logic [5:0]  cnt_z, cnt_n;

  // Wide instance: 64 x 64-bit, 4 read ports.
  logic [23:0]  w_rd_addr;
  logic         w_wr0_en, w_wr1_en, w_iss_en;
  logic [5:0]   w_wr0_addr, w_wr1_addr, w_iss_addr;
  logic [63:0]  w_wr0_data, w_wr1_data;
  logic [255:0] w_rd_data;
  logic [3:0]   w_rd_busy;
  logic [6:0]   w_cnt;

  int checks = 0;
  int failures = 0;

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(cnt_z)
  );

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_n (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(cnt_n)
  );

  regfile_mp_sb #(.DATA_W(64), .ADDR_W(6), .NUM_RD(4), .ZERO_REG(1)) dut_w (
    .clk(clk), .reset(reset), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .wr0_en(w_wr0_en), .wr0_addr(w_wr0_addr), .wr0_data(w_wr0_data),
    .wr1_en(w_wr1_en), .wr1_addr(w_wr1_addr), .wr1_data(w_wr1_data),
    .iss_en(w_iss_en), .iss_addr(w_iss_addr), .busy_cnt(w_cnt)
  );

  // Reference model, index 0 = zero register enabled, 1 = disabled.
  logic [31:0] m_regs [2][32];
  bit          m_pend [2][32];

  function automatic bit m_is_zero(int c, logic [4:0] a);
    return (c == 0) && (a == 5'd0);
  endfunction

  function automatic logic [31:0] exp_data(int c, logic [4:0] a);
    if (m_is_zero(c, a)) return 32'd0;
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
    return m_regs[c][a];
  endfunction

  function automatic bit exp_busy(int c, logic [4:0] a);
    if (m_is_zero(c, a)) return 1'b0;
    if ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a)) return 1'b0;
    return m_pend[c][a];
  endfunction

  function automatic int exp_cnt(int c);
    int n = 0;
    for (int a = 0; a < 32; a++) n += int'(m_pend[c][a]);
    return n;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 32; a++) begin
        m_regs[c][a] = 32'd0;
        m_pend[c][a] = 1'b0;
      end
  endtask

  // Apply the current inputs as the upcoming clock edge will.
  task automatic model_commit();
    for (int c = 0; c < 2; c++) begin
      if (wr0_en && !m_is_zero(c, wr0_addr)) m_regs[c][wr0_addr] = wr0_data;
      if (wr1_en && !m_is_zero(c, wr1_addr)) m_regs[c][wr1_addr] = wr1_data;
      for (int a = 0; a < 32; a++) begin
        bit written, issued;
        written = (wr0_en && wr0_addr == 5'(a)) || (wr1_en && wr1_addr == 5'(a));
        issued  = iss_en && iss_addr == 5'(a) && !m_is_zero(c, 5'(a));
        m_pend[c][a] = issued || (m_pend[c][a] && !written);
      end
    end
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; iss_en = 0;
    wr0_addr = 0; wr1_addr = 0; iss_addr = 0;
    wr0_data = 0; wr1_data = 0;
  endtask

  // Commit the model and advance one cycle; returns at the next falling edge.
  task automatic step();
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); iss_en = 1; iss_addr = 5; step();
    iss_addr = 12; step();
    idle(); wr0_en = 1; wr0_addr = 5; wr0_data = 32'h12345678; step();
    // Mid-operation reset while r5 is being written and r12 is pending.
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; rd_addr = {5'd12, 5'd5};
    #1 reset = 1;
    #1;
    checks++;
    if (rd_data_z !== 64'd0 || rd_data_n !== 64'd0) begin
      failures++;
      $display("FAIL reset_held_data: got %h/%h exp 0", rd_data_z, rd_data_n);
    end
    checks++;
    if (rd_busy_z !== 2'b00 || rd_busy_n !== 2'b00) begin
      failures++;
      $display("FAIL reset_held_busy: got %b/%b exp 00", rd_busy_z, rd_busy_n);
    end
    repeat (2) @(negedge clk);
    reset = 0;
    model_reset();
    idle();
    #1;
    checks++;
    if (rd_data_z !== 64'd0 || rd_data_n !== 64'd0) begin
      failures++;
      $display("FAIL reset_r5_r12: got %h/%h exp 0", rd_data_z, rd_data_n);
    end
    checks++;
    if (rd_busy_z !== 2'b00 || rd_busy_n !== 2'b00 || w_rd_busy !== 4'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b/%b/%b exp 0", rd_busy_z, rd_busy_n, w_rd_busy);
    end
    checks++;
    if (cnt_z !== 6'd0 || cnt_n !== 6'd0 || w_cnt !== 7'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d exp 0", cnt_z, cnt_n, w_cnt);
    end
    checks++;
    if (w_rd_data !== 256'd0) begin
      failures++;
      $display("FAIL reset_wide_data: got %h exp 0", w_rd_data);
    end
  endtask

  task automatic test_bypass();
    idle();
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11111111;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22222222;
    rd_addr = {5'd7, 5'd7};
    #1;
    checks++;
    if (rd_data_z[31:0] !== 32'h22222222 || rd_data_n[31:0] !== 32'h22222222) begin
      failures++;
      $display("FAIL bypass_priority: got %h/%h exp 22222222", rd_data_z[31:0],
               rd_data_n[31:0]);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd_data_z !== {2{32'h22222222}} || rd_data_n !== {2{32'h22222222}}) begin
      failures++;
      $display("FAIL bypass_stored: got %h/%h exp 22222222 x2", rd_data_z, rd_data_n);
    end
  endtask

  task automatic test_zero();
    logic [5:0] cz;
    cz = cnt_z;
    idle();
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
    iss_en = 1; iss_addr = 0;
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data_z[31:0] !== 32'd0 || rd_busy_z[0] !== 1'b0) begin
      failures++;
      $display("FAIL zero_read: got %h busy %b exp 0 busy 0", rd_data_z[31:0], rd_busy_z[0]);
    end
    checks++;
    if (rd_data_n[31:0] !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL nozero_bypass: got %h exp ffffffff", rd_data_n[31:0]);
    end
    step();
    idle();
    #1;
    checks++;
    if (cnt_z !== cz || rd_data_z[31:0] !== 32'd0) begin
      failures++;
      $display("FAIL zero_after: got cnt %0d data %h exp cnt %0d data 0", cnt_z,
               rd_data_z[31:0], cz);
    end
    checks++;
    if (rd_data_n[31:0] !== 32'hFFFFFFFF || rd_busy_n[0] !== 1'b1) begin
      failures++;
      $display("FAIL nozero_after: got %h busy %b exp ffffffff busy 1", rd_data_n[31:0],
               rd_busy_n[0]);
    end
  endtask

  task automatic test_scoreboard();
    idle(); iss_en = 1; iss_addr = 3; rd_addr = {5'd3, 5'd0};
    #1;
    checks++;
    if (rd_busy_z[1] !== 1'b0) begin
      failures++;
      $display("FAIL sb_same_cycle: got %b exp 0", rd_busy_z[1]);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd_busy_z[1] !== 1'b1 || cnt_z !== 6'd1) begin
      failures++;
      $display("FAIL sb_issued: got busy %b cnt %0d exp busy 1 cnt 1", rd_busy_z[1], cnt_z);
    end
    wr1_en = 1; wr1_addr = 3; wr1_data = 32'hA5A5A5A5;
    #1;
    checks++;
    if (rd_busy_z[1] !== 1'b0 || rd_data_z[63:32] !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL sb_writeback: got busy %b data %h exp busy 0 data a5a5a5a5",
               rd_busy_z[1], rd_data_z[63:32]);
    end
    step();
    idle();
    #1;
    checks++;
    if (cnt_z !== 6'd0 || rd_busy_z[1] !== 1'b0) begin
      failures++;
      $display("FAIL sb_retired: got cnt %0d busy %b exp cnt 0 busy 0", cnt_z, rd_busy_z[1]);
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] c1;
    idle(); iss_en = 1; iss_addr = 9; step();
    c1 = cnt_z;
    iss_en = 1; iss_addr = 9; wr0_en = 1; wr0_addr = 9; wr0_data = 32'h99;
    rd_addr = {5'd0, 5'd9};
    #1;
    checks++;
    if (rd_busy_z[0] !== 1'b0) begin
      failures++;
      $display("FAIL simul_write_hides_busy: got %b exp 0", rd_busy_z[0]);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd_busy_z[0] !== 1'b1 || cnt_z !== c1) begin
      failures++;
      $display("FAIL simul_set_wins: got busy %b cnt %0d exp busy 1 cnt %0d", rd_busy_z[0],
               cnt_z, c1);
    end
    iss_en = 1; iss_addr = 6; step();
    c1 = cnt_z;
    iss_en = 1; iss_addr = 4; wr1_en = 1; wr1_addr = 6; wr1_data = 32'h66;
    step();
    idle(); rd_addr = {5'd6, 5'd4};
    #1;
    checks++;
    if (cnt_z !== c1 || rd_busy_z !== 2'b01) begin
      failures++;
      $display("FAIL simul_set_clear: got cnt %0d busy %b exp cnt %0d busy 01", cnt_z,
               rd_busy_z, c1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      wr0_en = 1'($urandom); wr1_en = 1'($urandom); iss_en = 1'($urandom);
      wr0_addr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr1_addr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      iss_addr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr0_data = $urandom; wr1_data = $urandom;
      rd_addr = narrow ? {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))} : 10'($urandom);
      if (i % 97 == 50) begin
        reset = 1;
        #1 reset = 0;
        model_reset();
      end
      #1;
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 2; k++) begin
          logic [4:0]  a;
          logic [31:0] got_d;
          logic        got_b;
          a = rd_addr[k*5 +: 5];
          got_d = (c == 0) ? rd_data_z[k*32 +: 32] : rd_data_n[k*32 +: 32];
          got_b = (c == 0) ? rd_busy_z[k] : rd_busy_n[k];
          checks++;
          if (got_d !== exp_data(c, a)) begin
            failures++;
            $display("FAIL rand_data cfg%0d port%0d r%0d: got %h exp %h", c, k, a, got_d,
                     exp_data(c, a));
          end
          checks++;
          if (got_b !== exp_busy(c, a)) begin
            failures++;
            $display("FAIL rand_busy cfg%0d port%0d r%0d: got %b exp %b", c, k, a, got_b,
                     exp_busy(c, a));
          end
        end
      end
      step();
      checks++;
      if (cnt_z !== 6'(exp_cnt(0)) || cnt_n !== 6'(exp_cnt(1))) begin
        failures++;
        $display("FAIL rand_cnt: got %0d/%0d exp %0d/%0d", cnt_z, cnt_n, exp_cnt(0),
                 exp_cnt(1));
      end
    end
    idle();
  endtask

  task automatic test_wide();
    for (int j = 0; j < 32; j++) begin
      w_wr0_en = 1; w_wr0_addr = 6'(2 * j);     w_wr0_data = 64'(2 * j);
      w_wr1_en = 1; w_wr1_addr = 6'(2 * j + 1); w_wr1_data = 64'(2 * j + 1);
      @(posedge clk);
      @(negedge clk);
    end
    w_wr0_en = 0; w_wr1_en = 0;
    for (int j = 0; j < 16; j++) begin
      for (int p = 0; p < 4; p++) w_rd_addr[p*6 +: 6] = 6'(4 * j + ((p + j) % 4));
      #1;
      for (int p = 0; p < 4; p++) begin
        logic [5:0] a;
        a = w_rd_addr[p*6 +: 6];
        checks++;
        if (w_rd_data[p*64 +: 64] !== 64'(a)) begin
          failures++;
          $display("FAIL wide_read port%0d r%0d: got %h exp %h", p, a, w_rd_data[p*64 +: 64],
                   64'(a));
        end
      end
      @(negedge clk);
    end
    for (int r = 1; r < 64; r++) begin
      w_iss_en = 1; w_iss_addr = 6'(r);
      @(posedge clk);
      @(negedge clk);
      if (r == 1) begin
        checks++;
        if (w_cnt !== 7'd1) begin
          failures++;
          $display("FAIL wide_cnt_first: got %0d exp 1", w_cnt);
        end
      end
    end
    w_iss_en = 0;
    #1;
    checks++;
    if (w_cnt !== 7'd63) begin
      failures++;
      $display("FAIL wide_cnt_full: got %0d exp 63", w_cnt);
    end
    w_rd_addr = {6'd63, 6'd40, 6'd1, 6'd0};
    #1;
    checks++;
    if (w_rd_busy !== 4'b1110) begin
      failures++;
      $display("FAIL wide_busy: got %b exp 1110", w_rd_busy);
    end
  endtask

  initial begin
    reset = 1;
    idle();
    rd_addr = '0;
    w_rd_addr = '0; w_wr0_en = 0; w_wr1_en = 0; w_iss_en = 0;
    w_wr0_addr = '0; w_wr1_addr = '0; w_iss_addr = '0; w_wr0_data = '0; w_wr1_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    test_reset();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_simultaneous();
    test_random();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port register file with a built-in pending-write scoreboard. It is the next-generation CPU register file: configurable data width, depth and read-port count, and two write ports (ALU writeback and load/long-latency writeback). Same-cycle write-to-read bypass is provided on every read port. A per-register busy bit lets decode detect RAW hazards on results that are still outstanding.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
NUM_RD, 2, number of read ports, legal range 1..4
ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is an ordinary register

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  reset, asynchronous, active-high
rd_addr  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data per port (combinational)
rd_busy  output  NUM_RD  1 = the addressed register has an outstanding issued write that is not satisfied this cycle
wr0_en  input  1  write port 0 enable (ALU writeback)
wr0_addr  input  ADDR_W  write port 0 address
wr0_data  input  DATA_W  write port 0 data
wr1_en  input  1  write port 1 enable (load writeback)
wr1_addr  input  ADDR_W  write port 1 address
wr1_data  input  DATA_W  write port 1 data
iss_en  input  1  issue strobe: marks iss_addr as pending
iss_addr  input  ADDR_W  destination register of the issuing instruction
busy_cnt  output  ADDR_W+1  registered count of currently pending registers

Behaviour:
- Reset (asynchronous, any time, including mid-operation): all registers = 0, all pending bits = 0, busy_cnt = 0. Consequently rd_data = 0 and rd_busy = 0 for every port while reset is held.
- "Zero register" below means address 0 when ZERO_REG=1.
- Write, rising edge: if wrN_en and wrN_addr is not the zero register, reg[wrN_addr] <= wrN_data.
- If both ports write the same address in one cycle, wr1 wins (stored value = wr1_data).
- Read, combinational, per port k, in priority order:
  - zero register -> 0;
  - wr1_en and wr1_addr == rd_addr[k] -> wr1_data;
  - wr0_en and wr0_addr == rd_addr[k] -> wr0_data;
  - otherwise the stored value.
- Read latency is 0 cycles. Write-to-read visibility is same-cycle via the bypass.
- Scoreboard state: one pending bit per register.
  - Rising edge: the pending bit of any register written by wr0 or wr1 is cleared.
  - Then, if iss_en and iss_addr is not the zero register, pending[iss_addr] is set.
  - Set overrides clear when the issue and a write target the same address in the same cycle: the new producer remains outstanding.
  - Writes to non-pending registers are legal; the clear is a no-op.
  - iss_en to an already-pending register is legal; the bit stays 1 (WAW is handled by the issue logic, not here).
- rd_busy[k] = pending[rd_addr[k]] AND NOT (a write to rd_addr[k] is enabled this cycle). Forced 0 for the zero register.
- rd_busy does not reflect an iss_en in the same cycle; the new pending bit is visible from the next cycle.
- busy_cnt = popcount of the pending bits. It updates on the same edge as the pending bits and stays correct under any simultaneous set/clear combination. Its maximum is 2**ADDR_W (31 when ZERO_REG=1).
- When ZERO_REG=0, address 0 behaves like any other register for write, bypass and scoreboard.
- Unused upper bits do not exist: rd_addr and rd_data are exactly NUM_RD slices wide.

Test Plan:
- Reset then read: assert reset for 2 cycles mid-way through writing r5=0xDEADBEEF → on release, rd_data=0, rd_busy=0 and busy_cnt=0 on all ports; r5 reads 0.
- Bypass and priority: in the same cycle drive wr0 r7=0x11111111 and wr1 r7=0x22222222, with read port 0 = r7 → rd_data0=0x22222222 that cycle; next cycle r7 reads 0x22222222.
- Zero register: write r0=0xFFFFFFFF with iss_en on r0 → rd_data=0, rd_busy=0, busy_cnt unchanged. Repeat with ZERO_REG=0 → r0 reads 0xFFFFFFFF.
- Scoreboard lifecycle: issue r3 → next cycle rd_busy=1 and busy_cnt=1. On the wr1 r3=0xA5A5A5A5 cycle, rd_busy=0 and rd_data=0xA5A5A5A5; afterwards busy_cnt=0.
- Simultaneous issue and write on r9 while r9 is pending → pending stays 1 and busy_cnt is unchanged. Separately, issue r4 while writing pending r6 in the same cycle → busy_cnt is unchanged (one set, one clear).
- NUM_RD=4, DATA_W=64, ADDR_W=6: fill all 64 registers with their index, read 4 distinct ports each cycle → all 4 data outputs correct. Issue 63 distinct registers → busy_cnt=63.
